// File: rtl/bcd_timekeeper_pkg.sv
// Shared definitions for the BCD time-of-day core: set-state encoding,
// two-digit BCD limits and small BCD helpers used by the counters, the
// alarm comparator and the 12-hour output formatter.
package bcd_timekeeper_pkg;

   localparam int BCD_W = 8;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HRS = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } set_state_t;

   localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
   localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
   localparam logic [BCD_W-1:0] HRS_MAX = 8'h23;

   typedef struct packed {
      logic             pm;
      logic [BCD_W-1:0] hrs;
   } hour12_t;

   // Increment a two-digit BCD value, wrapping to 00 after max.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] val,
                                                input logic [BCD_W-1:0] max);
      logic [BCD_W-1:0] res;
      if (val == max) begin
         res = '0;
      end else if (val[3:0] == 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

   // Both digits decimal and the value not above max. With valid digits a
   // raw compare orders BCD values correctly.
   function automatic logic bcd_valid(input logic [BCD_W-1:0] val,
                                      input logic [BCD_W-1:0] max);
      return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
   endfunction

   // 24h BCD hour (00-23) to 12h BCD hour (01-12) plus PM flag.
   function automatic hour12_t to_hour12(input logic [BCD_W-1:0] h24);
      hour12_t          res;
      logic [BCD_W-1:0] bin;
      logic [BCD_W-1:0] diff;
      bin  = ({4'd0, h24[7:4]} * 8'd10) + {4'd0, h24[3:0]};
      diff = bin - 8'd12;
      res  = '{pm: 1'b0, hrs: h24};
      if (h24 == 8'h00) begin
         res = '{pm: 1'b0, hrs: 8'h12};
      end else if (h24 == 8'h12) begin
         res = '{pm: 1'b1, hrs: 8'h12};
      end else if (h24 > 8'h12) begin
         res.pm = 1'b1;
         if (diff >= 8'd10) begin
            res.hrs = {4'd1, diff[3:0] - 4'd10};
         end else begin
            res.hrs = {4'd0, diff[3:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_timekeeper_if.sv
// Control and display bundle of the timekeeper.
//   Run_En, Mode_Btn, Inc_Btn, Alarm_En, Alarm_Hrs, Alarm_Min : to the core
//   Sec, Min, Hrs, Pm, Set_Field, Blink, Tick_1s,
//   Day_Rollover, Alarm_Match                                : from the core
// master = board/controller side, slave = timekeeper core.
interface bcd_timekeeper_if;
   import bcd_timekeeper_pkg::*;

   logic             Run_En;
   logic             Mode_Btn;
   logic             Inc_Btn;
   logic             Alarm_En;
   logic [BCD_W-1:0] Alarm_Hrs;
   logic [BCD_W-1:0] Alarm_Min;
   logic [BCD_W-1:0] Sec;
   logic [BCD_W-1:0] Min;
   logic [BCD_W-1:0] Hrs;
   logic             Pm;
   logic [1:0]       Set_Field;
   logic             Blink;
   logic             Tick_1s;
   logic             Day_Rollover;
   logic             Alarm_Match;

   modport master (
      output Run_En, Mode_Btn, Inc_Btn, Alarm_En, Alarm_Hrs, Alarm_Min,
      input  Sec, Min, Hrs, Pm, Set_Field, Blink, Tick_1s, Day_Rollover, Alarm_Match
   );

   modport slave (
      input  Run_En, Mode_Btn, Inc_Btn, Alarm_En, Alarm_Hrs, Alarm_Min,
      output Sec, Min, Hrs, Pm, Set_Field, Blink, Tick_1s, Day_Rollover, Alarm_Match
   );

endinterface

// File: rtl/bcd_timekeeper_field_counter.sv
// Two-digit BCD field counter (seconds, minutes or hours).
//   Clk      : system clock
//   Resetn   : synchronous active-low reset, clears Count to 00
//   Enable   : advance by one, wrapping MAXCOUNT -> 00
//   Count    : current BCD value
//   Terminal : combinational, Count == MAXCOUNT (carry qualifier)
module bcd_field_counter
   import bcd_timekeeper_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAXCOUNT = 8'h59
) (
   input  logic             Clk,
   input  logic             Resetn,
   input  logic             Enable,
   output logic [BCD_W-1:0] Count,
   output logic             Terminal
);

   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         Count <= '0;
      end else if (Enable) begin
         Count <= bcd_inc(Count, MAXCOUNT);
      end
   end

   assign Terminal = (Count == MAXCOUNT);

endmodule

// File: rtl/bcd_timekeeper.sv
// Settable BCD time-of-day core with 1 s prescaler, button-driven time-set
// state machine, optional 12-hour output, day-rollover pulse and alarm.
//   Clk    : system clock
//   Resetn : synchronous active-low reset
//   tk     : bcd_timekeeper_if.slave (buttons, enables, alarm time in;
//            BCD time, Pm, Set_Field, Blink and event pulses out)
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_RUN     | time advances on each prescaler terminal count
// ST_SET_HRS | time frozen, Inc_Btn bumps hours (23 -> 00)
// ST_SET_MIN | time frozen, Inc_Btn bumps minutes (59 -> 00)
// ST_SET_SEC | time frozen, Inc_Btn bumps seconds; Mode returns to RUN
module bcd_timekeeper
   import bcd_timekeeper_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_DIV = CLK_HZ,
   parameter bit HOUR_12  = 1'b0
) (
   input  logic             Clk,
   input  logic             Resetn,
   bcd_timekeeper_if.slave  tk
);

   if (CLK_HZ <= 0 || TICK_DIV < 4 || (TICK_DIV % 4) != 0) begin : g_bad_params
      $error("bcd_timekeeper: TICK_DIV must be >= 4 and a multiple of 4");
   end

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(TICK_DIV - 1);
   localparam int BLINK_Q = TICK_DIV / 4;
   localparam int BLINK_W = (BLINK_Q > 1) ? $clog2(BLINK_Q) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_Q - 1);

   set_state_t       state_q, state_d;
   logic             running;
   logic             inc_hrs, inc_min, inc_sec;
   logic [PRESC_W-1:0] presc_cnt;
   logic             tick;
   logic [BLINK_W-1:0] blink_cnt;
   logic             blink_q;
   logic             rollover_q;
   logic             alarm_q;
   logic [BCD_W-1:0] sec_cnt, min_cnt, hrs_cnt;
   logic             sec_tc, min_tc, hrs_tc;
   logic [BCD_W-1:0] next_min, next_hrs;
   logic             alarm_hit;
   hour12_t          h12;

   // Set-state register
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-field increment strobes. Mode wins over Inc in the
   // same cycle, so an Inc coinciding with Mode is dropped.
   always_comb begin
      state_d = state_q;
      running = 1'b0;
      inc_hrs = 1'b0;
      inc_min = 1'b0;
      inc_sec = 1'b0;
      case (state_q)
         ST_RUN: begin
            running = 1'b1;
            if (tk.Mode_Btn) state_d = ST_SET_HRS;
         end
         ST_SET_HRS: begin
            if (tk.Mode_Btn) state_d = ST_SET_MIN;
            else             inc_hrs = tk.Inc_Btn;
         end
         ST_SET_MIN: begin
            if (tk.Mode_Btn) state_d = ST_SET_SEC;
            else             inc_min = tk.Inc_Btn;
         end
         ST_SET_SEC: begin
            if (tk.Mode_Btn) state_d = ST_RUN;
            else             inc_sec = tk.Inc_Btn;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Prescaler as a down-counter: the loaded value means "no cycles elapsed",
   // so reloading in SET states gives a full TICK_DIV interval after RUN resumes.
   always_ff @(posedge Clk) begin
      if (!Resetn || !running) begin
         presc_cnt <= PRESC_LOAD;
      end else if (tk.Run_En) begin
         if (presc_cnt == '0) presc_cnt <= PRESC_LOAD;
         else                 presc_cnt <= presc_cnt - 1'b1;
      end
   end

   assign tick = running && tk.Run_En && (presc_cnt == '0);

   bcd_field_counter #(.MAXCOUNT(SEC_MAX)) u_sec (
      .Clk      (Clk),
      .Resetn   (Resetn),
      .Enable   (tick || inc_sec),
      .Count    (sec_cnt),
      .Terminal (sec_tc)
   );

   bcd_field_counter #(.MAXCOUNT(MIN_MAX)) u_min (
      .Clk      (Clk),
      .Resetn   (Resetn),
      .Enable   ((tick && sec_tc) || inc_min),
      .Count    (min_cnt),
      .Terminal (min_tc)
   );

   bcd_field_counter #(.MAXCOUNT(HRS_MAX)) u_hrs (
      .Clk      (Clk),
      .Resetn   (Resetn),
      .Enable   ((tick && sec_tc && min_tc) || inc_hrs),
      .Count    (hrs_cnt),
      .Terminal (hrs_tc)
   );

   // Hour:minute the time will show after this tick; only meaningful when
   // seconds are at 59, which the alarm qualifier also requires.
   assign next_min  = bcd_inc(min_cnt, MIN_MAX);
   assign next_hrs  = min_tc ? bcd_inc(hrs_cnt, HRS_MAX) : hrs_cnt;
   assign alarm_hit = tk.Alarm_En && sec_tc &&
                      bcd_valid(tk.Alarm_Hrs, HRS_MAX) &&
                      bcd_valid(tk.Alarm_Min, MIN_MAX) &&
                      (next_hrs == tk.Alarm_Hrs) && (next_min == tk.Alarm_Min);

   // Event pulses line up with the first cycle the new time is visible.
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         rollover_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         rollover_q <= tick && sec_tc && min_tc && hrs_tc;
         alarm_q    <= tick && alarm_hit;
      end
   end

   // Blink runs in every state and ignores Run_En.
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         blink_cnt <= BLINK_LOAD;
         blink_q   <= 1'b0;
      end else if (blink_cnt == '0) begin
         blink_cnt <= BLINK_LOAD;
         blink_q   <= ~blink_q;
      end else begin
         blink_cnt <= blink_cnt - 1'b1;
      end
   end

   assign h12 = to_hour12(hrs_cnt);

   assign tk.Sec          = sec_cnt;
   assign tk.Min          = min_cnt;
   assign tk.Hrs          = HOUR_12 ? h12.hrs : hrs_cnt;
   assign tk.Pm           = HOUR_12 ? h12.pm : 1'b0;
   assign tk.Set_Field    = state_q;
   assign tk.Blink        = blink_q;
   assign tk.Tick_1s      = tick;
   assign tk.Day_Rollover = rollover_q;
   assign tk.Alarm_Match  = alarm_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
module tb_bcd_timekeeper;
   import bcd_timekeeper_pkg::*;

   localparam int TICK_DIV = 4;

   logic Clk = 1'b0;
   logic Resetn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   bcd_timekeeper_if if24();
   bcd_timekeeper_if if12();

   bcd_timekeeper #(.CLK_HZ(50000000), .TICK_DIV(TICK_DIV), .HOUR_12(1'b0)) dut24 (
      .Clk(Clk), .Resetn(Resetn), .tk(if24)
   );
   bcd_timekeeper #(.CLK_HZ(50000000), .TICK_DIV(TICK_DIV), .HOUR_12(1'b1)) dut12 (
      .Clk(Clk), .Resetn(Resetn), .tk(if12)
   );

   assign if12.Run_En    = if24.Run_En;
   assign if12.Mode_Btn  = if24.Mode_Btn;
   assign if12.Inc_Btn   = if24.Inc_Btn;
   assign if12.Alarm_En  = if24.Alarm_En;
   assign if12.Alarm_Hrs = if24.Alarm_Hrs;
   assign if12.Alarm_Min = if24.Alarm_Min;

   always #5 Clk = ~Clk;

   // Reference model: time as seconds of day, state index, elapsed prescaler cycles.
   int  m_secs = 0, m_st = 0, m_pel = 0, m_bcnt = 0;
   bit  m_blink = 0, m_roll = 0, m_alarm = 0, m_valid = 0;
   bit  m_tick;
   int  m_ah, m_am, m_nxt, m_h, m_m, m_s;

   // Observed-event counters for the directed literal checks.
   int   tick_count = 0, roll_pulses = 0, alarm_pulses = 0, blink_toggles = 0;
   bit   bad_digit = 0;
   logic prev_blink = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic int from_bcd(input logic [7:0] b, input int lim);
      int v;
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
      v = int'(b[7:4]) * 10 + int'(b[3:0]);
      if (v > lim) return -1;
      return v;
   endfunction

   task automatic compare();
      int h, m, s, h12;
      bit pm, etick;
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      s = m_secs % 60;
      pm = (h >= 12);
      h12 = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
      etick = (m_st == 0) && if24.Run_En && (m_pel == TICK_DIV - 1);
      chk("sec", if24.Sec, to_bcd(s));
      chk("min", if24.Min, to_bcd(m));
      chk("hrs24", if24.Hrs, to_bcd(h));
      chk("pm24", if24.Pm, 0);
      chk("hrs12", if12.Hrs, to_bcd(h12));
      chk("pm12", if12.Pm, pm);
      chk("min12", if12.Min, to_bcd(m));
      chk("field", if24.Set_Field, m_st);
      chk("blink", if24.Blink, m_blink);
      chk("tick", if24.Tick_1s, etick);
      chk("rollover", if24.Day_Rollover, m_roll);
      chk("alarm", if24.Alarm_Match, m_alarm);
      chk("alarm12", if12.Alarm_Match, m_alarm);
      if (if24.Tick_1s === 1'b1) tick_count++;
      if (if24.Day_Rollover === 1'b1) roll_pulses++;
      if (if24.Alarm_Match === 1'b1) alarm_pulses++;
      if (if24.Blink !== prev_blink) blink_toggles++;
      prev_blink = if24.Blink;
      if (if24.Sec[3:0] > 4'd9 || if24.Sec[7:4] > 4'd5) bad_digit = 1'b1;
   endtask

   always @(posedge Clk) begin
      if (!Resetn) begin
         m_secs = 0; m_st = 0; m_pel = 0; m_bcnt = 0;
         m_blink = 0; m_roll = 0; m_alarm = 0; m_valid = 1;
      end else begin
         m_tick  = (m_st == 0) && if24.Run_En && (m_pel == TICK_DIV - 1);
         m_nxt   = (m_secs + 1) % 86400;
         m_ah    = from_bcd(if24.Alarm_Hrs, 23);
         m_am    = from_bcd(if24.Alarm_Min, 59);
         m_roll  = m_tick && (m_secs == 86399);
         m_alarm = m_tick && if24.Alarm_En && (m_ah >= 0) && (m_am >= 0) &&
                   (m_nxt == m_ah * 3600 + m_am * 60);
         if (m_tick) m_secs = m_nxt;
         if (m_st != 0 && if24.Inc_Btn && !if24.Mode_Btn) begin
            m_h = m_secs / 3600; m_m = (m_secs / 60) % 60; m_s = m_secs % 60;
            case (m_st)
               1:       m_h = (m_h + 1) % 24;
               2:       m_m = (m_m + 1) % 60;
               default: m_s = (m_s + 1) % 60;
            endcase
            m_secs = m_h * 3600 + m_m * 60 + m_s;
         end
         if (m_st != 0) m_pel = 0;
         else if (if24.Run_En) m_pel = (m_pel + 1) % TICK_DIV;
         if (if24.Mode_Btn) m_st = (m_st + 1) % 4;
         m_bcnt++;
         if (m_bcnt == TICK_DIV / 4) begin
            m_bcnt = 0;
            m_blink = !m_blink;
         end
      end
      #1;
      if (m_valid) compare();
   end

   task automatic pulse(input bit md, input bit inc);
      if24.Mode_Btn = md;
      if24.Inc_Btn  = inc;
      @(negedge Clk);
      if24.Mode_Btn = 1'b0;
      if24.Inc_Btn  = 1'b0;
   endtask

   // Reset, then walk the set states to load h:m:s; returns in the first RUN cycle.
   task automatic set_time(input int h, input int m, input int s);
      Resetn = 1'b0;
      @(negedge Clk);
      Resetn = 1'b1;
      pulse(1, 0);
      repeat (h) pulse(0, 1);
      pulse(1, 0);
      repeat (m) pulse(0, 1);
      pulse(1, 0);
      repeat (s) pulse(0, 1);
      pulse(1, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   int snap_a, snap_b, snap_c;
   logic [7:0] snap_sec;

   initial begin
      if24.Run_En = 1'b1; if24.Mode_Btn = 1'b0; if24.Inc_Btn = 1'b0;
      if24.Alarm_En = 1'b0; if24.Alarm_Hrs = 8'h00; if24.Alarm_Min = 8'h00;
      Resetn = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset state
      chk("rst_sec", if24.Sec, 8'h00);
      chk("rst_hrs24", if24.Hrs, 8'h00);
      chk("rst_hrs12", if12.Hrs, 8'h12);
      chk("rst_pm12", if12.Pm, 1'b0);
      chk("rst_field", if24.Set_Field, 2'd0);
      chk("rst_blink", if24.Blink, 1'b0);

      // Free run for 240 cycles
      Resetn = 1'b1;
      snap_a = tick_count;
      repeat (240) @(negedge Clk);
      chk("run_sec", if24.Sec, 8'h00);
      chk("run_min", if24.Min, 8'h01);
      chk("run_hrs", if24.Hrs, 8'h00);
      chk("run_ticks", tick_count - snap_a, 60);
      chk("run_digits", bad_digit, 1'b0);

      // Day rollover
      set_time(23, 59, 59);
      snap_a = roll_pulses;
      repeat (3) @(negedge Clk);
      chk("roll_tick", if24.Tick_1s, 1'b1);
      chk("roll_early", if24.Day_Rollover, 1'b0);
      @(negedge Clk);
      chk("roll_pulse", if24.Day_Rollover, 1'b1);
      chk("roll_hrs", if24.Hrs, 8'h00);
      chk("roll_min", if24.Min, 8'h00);
      chk("roll_sec", if24.Sec, 8'h00);
      repeat (3) @(negedge Clk);
      chk("roll_count", roll_pulses - snap_a, 1);

      // 12-hour formatting
      if24.Run_En = 1'b0;
      set_time(0, 0, 0);
      chk("h12_00", {if12.Pm, if12.Hrs}, 9'h012);
      set_time(13, 0, 0);
      chk("h12_13", {if12.Pm, if12.Hrs}, 9'h101);
      set_time(12, 0, 0);
      chk("h12_12", {if12.Pm, if12.Hrs}, 9'h112);
      if24.Run_En = 1'b1;
      set_time(11, 59, 59);
      repeat (3) @(negedge Clk);
      chk("h12_pre", {if12.Pm, if12.Hrs}, 9'h011);
      @(negedge Clk);
      chk("h12_noon", {if12.Pm, if12.Hrs}, 9'h112);
      chk("h12_noon_min", if12.Min, 8'h00);

      // Field wrap, Mode+Inc, Inc in RUN
      if24.Run_En = 1'b0;
      set_time(5, 59, 0);
      pulse(1, 0);
      pulse(1, 0);
      pulse(0, 1);
      chk("wrap_min", if24.Min, 8'h00);
      chk("wrap_hrs", if24.Hrs, 8'h05);
      pulse(1, 1);
      chk("modeinc_field", if24.Set_Field, 2'd3);
      chk("modeinc_sec", if24.Sec, 8'h00);
      pulse(1, 0);
      pulse(0, 1);
      chk("runinc_field", if24.Set_Field, 2'd0);
      chk("runinc_time", {if24.Hrs, if24.Min, if24.Sec}, 24'h050000);

      // Alarm
      if24.Alarm_Hrs = 8'h07; if24.Alarm_Min = 8'h30; if24.Alarm_En = 1'b1;
      if24.Run_En = 1'b1;
      set_time(7, 29, 59);
      snap_a = alarm_pulses;
      repeat (4) @(negedge Clk);
      chk("alarm_pulse", if24.Alarm_Match, 1'b1);
      chk("alarm_time", {if24.Hrs, if24.Min, if24.Sec}, 24'h073000);
      repeat (4) @(negedge Clk);
      chk("alarm_count", alarm_pulses - snap_a, 1);
      if24.Alarm_En = 1'b0;
      set_time(7, 29, 59);
      snap_a = alarm_pulses;
      repeat (8) @(negedge Clk);
      chk("alarm_off", alarm_pulses - snap_a, 0);
      if24.Alarm_En = 1'b1;
      if24.Run_En = 1'b0;
      snap_a = alarm_pulses;
      set_time(7, 30, 0);
      repeat (4) @(negedge Clk);
      chk("alarm_manual", alarm_pulses - snap_a, 0);
      if24.Alarm_En = 1'b0;

      // Reset mid-set, then Run_En freeze
      set_time(10, 20, 30);
      pulse(1, 0);
      pulse(1, 0);
      chk("midset_field", if24.Set_Field, 2'd2);
      Resetn = 1'b0;
      @(negedge Clk);
      chk("midset_time", {if24.Hrs, if24.Min, if24.Sec}, 24'h000000);
      chk("midset_field0", if24.Set_Field, 2'd0);
      chk("midset_pulses", {if24.Tick_1s, if24.Day_Rollover, if24.Alarm_Match, if24.Blink}, 4'b0000);
      Resetn = 1'b1;
      if24.Run_En = 1'b1;
      repeat (6) @(negedge Clk);
      if24.Run_En = 1'b0;
      snap_sec = if24.Sec;
      snap_b = blink_toggles;
      snap_c = tick_count;
      repeat (10) @(negedge Clk);
      chk("freeze_sec", if24.Sec, snap_sec);
      chk("freeze_ticks", tick_count - snap_c, 0);
      chk("freeze_blink", blink_toggles - snap_b, 10);
      if24.Run_En = 1'b1;
      repeat (8) @(negedge Clk);

      // Randomized phase
      for (int it = 0; it < 10; it++) begin
         if24.Run_En = 1'b1;
         set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(50, 59));
         if ($urandom_range(0, 3) == 0) begin
            if24.Alarm_Hrs = 8'($urandom);
            if24.Alarm_Min = 8'($urandom);
         end else begin
            snap_a = ((m_secs / 60) + 1) % 1440;
            if24.Alarm_Hrs = to_bcd(snap_a / 60);
            if24.Alarm_Min = to_bcd(snap_a % 60);
         end
         if24.Alarm_En = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < 300; c++) begin
            if24.Run_En   = ($urandom_range(0, 7) != 0);
            if24.Mode_Btn = ($urandom_range(0, 59) == 0);
            if24.Inc_Btn  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) if24.Alarm_En = ~if24.Alarm_En;
            Resetn = ($urandom_range(0, 399) != 0);
            @(negedge Clk);
         end
         if24.Mode_Btn = 1'b0;
         if24.Inc_Btn  = 1'b0;
         Resetn = 1'b1;
      end

      @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
